// File: rtl/exec_stage_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the execute-stage hazard
// controller. The datapath side is the master (it supplies register numbers,
// write enables and unit status). The controller side is the slave (it returns
// stall, flush and forwarding controls).
interface exec_stage_hazard_ctrl_if;
    logic [3:0] RA1D;
    logic [3:0] RA2D;
    logic [3:0] RA1E;
    logic [3:0] RA2E;
    logic [3:0] WA3E;
    logic       RegWE;
    logic       MemtoRegE;
    logic [3:0] WA3M;
    logic [3:0] WA3W;
    logic       RegWriteM;
    logic       RegWriteW;
    logic       BranchTakenE;
    logic       StartE;
    logic       MBusy;
    logic       Float_startE;
    logic       FBusy;
    logic       StallF;
    logic       StallD;
    logic       FlushD;
    logic       FlashE;
    logic       Mstall;
    logic [1:0] ForwardAE;
    logic [1:0] ForwardBE;
    logic       Err;

    modport master (
        output RA1D, RA2D, RA1E, RA2E, WA3E, RegWE, MemtoRegE, WA3M, WA3W,
               RegWriteM, RegWriteW, BranchTakenE, StartE, MBusy, Float_startE, FBusy,
        input  StallF, StallD, FlushD, FlashE, Mstall, ForwardAE, ForwardBE, Err
    );

    modport slave (
        input  RA1D, RA2D, RA1E, RA2E, WA3E, RegWE, MemtoRegE, WA3M, WA3W,
               RegWriteM, RegWriteW, BranchTakenE, StartE, MBusy, Float_startE, FBusy,
        output StallF, StallD, FlushD, FlashE, Mstall, ForwardAE, ForwardBE, Err
    );
endinterface

// File: rtl/exec_stage_hazard_ctrl.sv
// Execute-stage hazard controller. Sequences MCycle and float ops through a
// small FSM (holding the Decode->Execute register while they run), detects
// load-use hazards and taken branches, and raises a sticky Err flag if a unit
// stays busy too long.
// Optional feature macro: HAZ_FWD_EN enables operand forwarding selects.
// Without it the forwarding selects are 00 and any RAW on the Execute or
// Memory destination stalls instead.
module exec_stage_hazard_ctrl #(
    parameter int TIMEOUT_CYC = 64
) (
    input logic                     CLK,
    input logic                     RESET,
    exec_stage_hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {RUN, MWAIT, FWAIT, DRAIN} state_t;

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    state_t        state;
    state_t        state_next;
    logic          pend;
    logic          pend_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          err;
    logic          err_next;
    logic          mstall;
    logic          raw_e;
    logic          lu;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;

    // State register, pending-float flag, wait counter and sticky error flag
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= RUN;
            pend  <= 1'b0;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            pend  <= pend_next;
            cnt   <= cnt_next;
            err   <= err_next;
        end
    end

    // Next-state logic; the counter only advances while a unit is still busy and clears otherwise
    always_comb begin
        state_next = state;
        pend_next  = pend;
        cnt_next   = '0;
        err_next   = err;
        case (state)
            RUN: begin
                if (bus.StartE) begin
                    state_next = MWAIT;
                    pend_next  = bus.Float_startE;
                end else if (bus.Float_startE) begin
                    state_next = FWAIT;
                end
            end
            MWAIT: begin
                if (!bus.MBusy) begin
                    if (pend) begin
                        pend_next  = 1'b0;
                        state_next = FWAIT;
                    end else begin
                        state_next = DRAIN;
                    end
                end else if (cnt == CNT_LAST) begin
                    err_next   = 1'b1;
                    pend_next  = 1'b0;
                    state_next = DRAIN;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            FWAIT: begin
                if (!bus.FBusy) begin
                    state_next = DRAIN;
                end else if (cnt == CNT_LAST) begin
                    err_next   = 1'b1;
                    pend_next  = 1'b0;
                    state_next = DRAIN;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            DRAIN: state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    assign mstall = (state != RUN) || bus.StartE || bus.Float_startE;
    assign raw_e  = (bus.WA3E == bus.RA1D) || (bus.WA3E == bus.RA2D);

`ifdef HAZ_FWD_EN
    // Memory-stage result wins over Writeback because it is the younger value
    function automatic logic [1:0] fwd_sel(input logic [3:0] ra,
                                           input logic wr_m, input logic [3:0] wa_m,
                                           input logic wr_w, input logic [3:0] wa_w);
        if (wr_m && (wa_m == ra))      return 2'b10;
        else if (wr_w && (wa_w == ra)) return 2'b01;
        else                           return 2'b00;
    endfunction

    assign fwd_a = fwd_sel(bus.RA1E, bus.RegWriteM, bus.WA3M, bus.RegWriteW, bus.WA3W);
    assign fwd_b = fwd_sel(bus.RA2E, bus.RegWriteM, bus.WA3M, bus.RegWriteW, bus.WA3W);

    // Only a load's result arrives too late to forward
    assign lu = bus.MemtoRegE && bus.RegWE && (bus.WA3E != 4'd15) && raw_e;
`else
    logic raw_m;
    logic unused_fwd_inputs;

    assign fwd_a = 2'b00;
    assign fwd_b = 2'b00;
    assign raw_m = (bus.WA3M == bus.RA1D) || (bus.WA3M == bus.RA2D);

    // No forwarding path, so any pending write to a Decode source must be waited out
    assign lu = (bus.RegWE && (bus.WA3E != 4'd15) && raw_e)
             || (bus.RegWriteM && (bus.WA3M != 4'd15) && raw_m);

    assign unused_fwd_inputs = ^{bus.RA1E, bus.RA2E, bus.WA3W, bus.RegWriteW, bus.MemtoRegE};
`endif

    // Output priority: multi-cycle hold, then taken branch, then load-use; everything low in reset
    always_comb begin
        bus.StallF    = 1'b0;
        bus.StallD    = 1'b0;
        bus.FlushD    = 1'b0;
        bus.FlashE    = 1'b0;
        bus.Mstall    = 1'b0;
        bus.ForwardAE = 2'b00;
        bus.ForwardBE = 2'b00;
        bus.Err       = 1'b0;
        if (!RESET) begin
            bus.Err       = err;
            bus.ForwardAE = fwd_a;
            bus.ForwardBE = fwd_b;
            if (mstall) begin
                bus.Mstall = 1'b1;
                bus.StallF = 1'b1;
                bus.StallD = 1'b1;
            end else if (bus.BranchTakenE) begin
                bus.FlushD = 1'b1;
                bus.FlashE = 1'b1;
            end else if (lu) begin
                bus.StallF = 1'b1;
                bus.StallD = 1'b1;
                bus.FlashE = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_exec_stage_hazard_ctrl.sv
// Testbench for exec_stage_hazard_ctrl (TIMEOUT_CYC = 8).
// Each driven cycle pushes its expected output vector onto a scoreboard queue;
// a negedge monitor pops and compares against the DUT outputs.
// Vector layout: {StallF, StallD, FlushD, FlashE, Mstall, Err, ForwardAE, ForwardBE}.
module tb_exec_stage_hazard_ctrl;

`ifdef HAZ_FWD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    typedef struct {
        string      tag;
        logic [9:0] expected;
    } sb_item_t;

    logic     clk;
    logic     reset;
    int       checks;
    int       failures;
    sb_item_t sb[$];

    exec_stage_hazard_ctrl_if hif();

    exec_stage_hazard_ctrl #(.TIMEOUT_CYC(8)) dut (
        .CLK   (clk),
        .RESET (reset),
        .bus   (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] exp_vec(input logic sf, input logic sd, input logic fd,
                                           input logic fe, input logic ms, input logic er,
                                           input logic [1:0] fa, input logic [1:0] fb);
        return {sf, sd, fd, fe, ms, er, fa, fb};
    endfunction

    localparam logic [9:0] V_IDLE    = 10'b0;
    localparam logic [9:0] V_MST     = 10'b11001_0_00_00;
    localparam logic [9:0] V_MST_ERR = 10'b11001_1_00_00;
    localparam logic [9:0] V_LU      = 10'b11010_0_00_00;
    localparam logic [9:0] V_BR      = 10'b00110_0_00_00;
    localparam logic [9:0] V_ERR     = 10'b00000_1_00_00;

    task automatic checkOutput(input string tag, input logic [9:0] observed, input logic [9:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [9:0] expected);
        sb_item_t item;
        item.tag      = tag;
        item.expected = expected;
        sb.push_back(item);
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        hif.RA1D         = 4'd1;
        hif.RA2D         = 4'd2;
        hif.RA1E         = 4'd5;
        hif.RA2E         = 4'd6;
        hif.WA3E         = 4'd9;
        hif.WA3M         = 4'd10;
        hif.WA3W         = 4'd11;
        hif.RegWE        = 1'b0;
        hif.MemtoRegE    = 1'b0;
        hif.RegWriteM    = 1'b0;
        hif.RegWriteW    = 1'b0;
        hif.BranchTakenE = 1'b0;
        hif.StartE       = 1'b0;
        hif.MBusy        = 1'b0;
        hif.Float_startE = 1'b0;
        hif.FBusy        = 1'b0;
    endtask

    // Monitor: compare DUT outputs against the oldest expectation, away from the clock edge
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            sb_item_t item;
            item = sb.pop_front();
            checkOutput(item.tag,
                        {hif.StallF, hif.StallD, hif.FlushD, hif.FlashE, hif.Mstall,
                         hif.Err, hif.ForwardAE, hif.ForwardBE},
                        item.expected);
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        set_idle();
        @(posedge clk);
        #1;

        // Reset: everything low even with ops, hazards and branch requested
        hif.StartE = 1'b1; hif.Float_startE = 1'b1; hif.BranchTakenE = 1'b1;
        hif.MemtoRegE = 1'b1; hif.RegWE = 1'b1; hif.WA3E = 4'd1;
        applyStimulus("reset_hold", V_IDLE);
        applyStimulus("reset_hold", V_IDLE);
        set_idle();
        reset = 1'b0;
        applyStimulus("idle_after_reset", V_IDLE);

        // Both ops: MCycle busy 3 cycles, then float busy 2 cycles, one contiguous stall
        hif.StartE = 1'b1; hif.Float_startE = 1'b1; hif.MBusy = 1'b1;
        applyStimulus("both_entry", V_MST);
        applyStimulus("both_mwait", V_MST);
        applyStimulus("both_mwait", V_MST);
        hif.MBusy = 1'b0;
        applyStimulus("both_mdone", V_MST);
        hif.FBusy = 1'b1;
        applyStimulus("both_fwait", V_MST);
        applyStimulus("both_fwait", V_MST);
        hif.FBusy = 1'b0;
        applyStimulus("both_fdone", V_MST);
        applyStimulus("both_drain", V_MST);
        hif.StartE = 1'b0; hif.Float_startE = 1'b0;
        applyStimulus("both_run", V_IDLE);

        // MCycle busy 5 cycles: 7 stall cycles; branch and load-use masked mid-way
        hif.StartE = 1'b1; hif.MBusy = 1'b1;
        applyStimulus("m_entry", V_MST);
        for (int i = 1; i < 5; i++) begin
            hif.BranchTakenE = (i == 2);
            hif.MemtoRegE    = (i == 2);
            hif.RegWE        = (i == 2);
            hif.WA3E         = (i == 2) ? 4'd1 : 4'd9;
            applyStimulus("m_wait_masked", V_MST);
        end
        hif.MBusy = 1'b0;
        applyStimulus("m_done", V_MST);
        applyStimulus("m_drain", V_MST);
        hif.StartE = 1'b0;
        applyStimulus("m_run", V_IDLE);

        // Float only, with MBusy asserted to show it is ignored in FWAIT
        hif.Float_startE = 1'b1; hif.FBusy = 1'b1; hif.MBusy = 1'b1;
        applyStimulus("f_entry", V_MST);
        applyStimulus("f_wait", V_MST);
        hif.FBusy = 1'b0;
        applyStimulus("f_done", V_MST);
        applyStimulus("f_drain", V_MST);
        hif.Float_startE = 1'b0; hif.MBusy = 1'b0;
        applyStimulus("f_run", V_IDLE);

        // Load-use on RA2D: one bubble, then cleared
        hif.MemtoRegE = 1'b1; hif.RegWE = 1'b1; hif.WA3E = 4'd3; hif.RA2D = 4'd3;
        applyStimulus("lu_ra2", V_LU);
        hif.MemtoRegE = 1'b0; hif.RegWE = 1'b0;
        applyStimulus("lu_bubble_gone", V_IDLE);
        hif.MemtoRegE = 1'b1; hif.RegWE = 1'b1; hif.WA3E = 4'd1; hif.RA2D = 4'd2;
        applyStimulus("lu_ra1", V_LU);
        hif.WA3E = 4'd15; hif.RA1D = 4'd15;
        applyStimulus("lu_pc_excluded", V_IDLE);
        set_idle();

        // Branch overrides load-use
        hif.MemtoRegE = 1'b1; hif.RegWE = 1'b1; hif.WA3E = 4'd2; hif.BranchTakenE = 1'b1;
        applyStimulus("branch_over_lu", V_BR);
        hif.MemtoRegE = 1'b0; hif.RegWE = 1'b0; hif.WA3E = 4'd9;
        applyStimulus("branch_alone", V_BR);
        set_idle();

        // Non-load RAW on Execute and RAW on Memory: stall only without forwarding
        hif.RegWE = 1'b1; hif.WA3E = 4'd1;
        applyStimulus("alu_raw_e", FWD_ON ? V_IDLE : V_LU);
        set_idle();
        hif.RegWriteM = 1'b1; hif.WA3M = 4'd2;
        applyStimulus("raw_m", FWD_ON ? V_IDLE : V_LU);
        set_idle();

        // Forwarding selects
        hif.WA3M = 4'd4; hif.WA3W = 4'd4; hif.RA1E = 4'd4;
        hif.RegWriteM = 1'b1; hif.RegWriteW = 1'b1;
        applyStimulus("fwd_a_mem_prio", exp_vec(0, 0, 0, 0, 0, 0, FWD_ON ? 2'b10 : 2'b00, 2'b00));
        hif.RegWriteM = 1'b0;
        applyStimulus("fwd_a_wb", exp_vec(0, 0, 0, 0, 0, 0, FWD_ON ? 2'b01 : 2'b00, 2'b00));
        hif.RegWriteM = 1'b1; hif.RegWriteW = 1'b0; hif.RA1E = 4'd5; hif.RA2E = 4'd4;
        applyStimulus("fwd_b_mem", exp_vec(0, 0, 0, 0, 0, 0, 2'b00, FWD_ON ? 2'b10 : 2'b00));
        hif.RegWriteM = 1'b0;
        applyStimulus("fwd_none", V_IDLE);
        set_idle();

        // Timeout: MBusy stuck, forced DRAIN after 8 MWAIT cycles, Err sticky
        hif.StartE = 1'b1; hif.MBusy = 1'b1;
        applyStimulus("to_entry", V_MST);
        for (int i = 0; i < 8; i++) applyStimulus("to_mwait", V_MST);
        applyStimulus("to_drain", V_MST_ERR);
        hif.StartE = 1'b0; hif.MBusy = 1'b0;
        applyStimulus("to_err_hold", V_ERR);
        applyStimulus("to_err_hold", V_ERR);
        hif.MemtoRegE = 1'b1; hif.RegWE = 1'b1; hif.WA3E = 4'd1;
        applyStimulus("to_err_with_lu", V_LU | V_ERR);
        set_idle();

        // Reset mid-operation: outputs drop at once, FSM back in RUN afterwards
        hif.StartE = 1'b1; hif.MBusy = 1'b1;
        applyStimulus("rst_mid_entry", V_MST_ERR);
        applyStimulus("rst_mid_wait", V_MST_ERR);
        reset = 1'b1;
        applyStimulus("rst_mid_assert", V_IDLE);
        reset = 1'b0; hif.StartE = 1'b0;
        applyStimulus("rst_mid_run", V_IDLE);
        applyStimulus("rst_mid_run", V_IDLE);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_drain: %0d left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
